alu_response_checker: RTL and testbench

//  Synthesizable self-check engine for the ALU_8bit datapath. Consumes a stream of issued

---
 rtl/alu_response_checker.sv | 165 ++++++++++++++++
 tb/tb_alu_response_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// alu_response_checker: recomputes the golden ALU_8bit result for every issued
// beat and keeps saturating pass/fail/skip counts plus the first failing index.
// Each beat is registered once, then compared; the score updates one cycle later.
module alu_response_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [CNT_W-1:0] rem_q, idx_q;

  logic             stg_vld_q, stg_cin_q, stg_cout_q;
  logic [1:0]       stg_op_q;
  logic [WIDTH-1:0] stg_a_q, stg_b_q, stg_res_q;
  logic [CNT_W-1:0] stg_idx_q;

  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q, skip_cnt_q, ff_idx_q;
  logic             ff_vld_q, mis_q;

  logic             accept, start_ok;
  logic [WIDTH:0]   sum;
  logic             cmp_fail, cmp_skip;

  assign accept   = in_valid && (state_q == S_RUN);
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Run control: beats remaining and the index handed to the next accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            rem_q   <= num_tests;
            idx_q   <= '0;
            state_q <= (num_tests == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            rem_q <= rem_q - ONE;
            idx_q <= idx_q + ONE;
            if (rem_q == ONE) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Capture stage: holds the accepted beat for the compare in the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q  <= 1'b0;
      stg_op_q   <= '0;
      stg_a_q    <= '0;
      stg_b_q    <= '0;
      stg_cin_q  <= 1'b0;
      stg_res_q  <= '0;
      stg_cout_q <= 1'b0;
      stg_idx_q  <= '0;
    end else begin
      stg_vld_q <= accept;
      if (accept) begin
        stg_op_q   <= in_op;
        stg_a_q    <= in_a;
        stg_b_q    <= in_b;
        stg_cin_q  <= in_cin;
        stg_res_q  <= in_result;
        stg_cout_q <= in_cout;
        stg_idx_q  <= idx_q;
      end
    end
  end

  assign sum = {1'b0, stg_a_q} + {1'b0, stg_b_q} + {{WIDTH{1'b0}}, stg_cin_q};

  // Golden compare; carry-out only matters for ADD, op 11 is skipped
  always_comb begin
    cmp_fail = 1'b0;
    cmp_skip = 1'b0;
    case (stg_op_q)
      2'b00:   cmp_fail = (stg_res_q != (stg_a_q & stg_b_q));
      2'b01:   cmp_fail = (stg_res_q != (stg_a_q | stg_b_q));
      2'b10:   cmp_fail = ({stg_cout_q, stg_res_q} != sum);
      default: cmp_skip = 1'b1;
    endcase
  end

  // Scoreboard: saturating counters, mismatch pulse, first-failure latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      skip_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_vld_q   <= 1'b0;
      mis_q      <= 1'b0;
    end else if (start_ok) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      skip_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_vld_q   <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      mis_q <= stg_vld_q && !cmp_skip && cmp_fail;
      if (stg_vld_q) begin
        if (cmp_skip) begin
          if (skip_cnt_q != '1) skip_cnt_q <= skip_cnt_q + ONE;
        end else if (cmp_fail) begin
          if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + ONE;
          if (!ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_idx_q <= stg_idx_q;
          end
        end else begin
          if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + ONE;
        end
      end
    end
  end

  assign in_ready       = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (fail_cnt_q == '0);
  assign mismatch       = mis_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign skip_cnt       = skip_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Bench for alu_response_checker: a directed beat table, then hand-written
// sequences for restart, empty runs, gapped random ADD traffic and mid-run reset.
module tb_alu_response_checker;

  logic        clk, rst_n, start, in_valid, in_ready, in_cin, in_cout;
  logic [15:0] num_tests;
  logic [1:0]  in_op;
  logic [7:0]  in_a, in_b, in_result;
  logic        busy, done, pass, mismatch, first_fail_vld;
  logic [15:0] pass_cnt, fail_cnt, skip_cnt, first_fail_idx;

  int n_cmp = 0;
  int n_bad = 0;

  alu_response_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tests(num_tests),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_result(in_result), .in_cout(in_cout),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       exp_mis;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_tests = n;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b;
    in_cin = v.cin; in_result = v.res; in_cout = v.cout;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " mismatch"}, mismatch, 0);
    chk({tag, " pass_cnt"}, pass_cnt, 0);
    chk({tag, " fail_cnt"}, fail_cnt, 0);
    chk({tag, " skip_cnt"}, skip_cnt, 0);
    chk({tag, " ff_idx"}, first_fail_idx, 0);
    chk({tag, " ff_vld"}, first_fail_vld, 0);
  endtask

  initial begin
    int sent, mis_seen, m_pass, m_fail, m_ffidx, cyc;
    logic [8:0] s;
    vec_t v;

    //         op     a      b      cin   res    cout  exp_mis
    vecs[0] = '{2'b00, 8'hAA, 8'hCC, 1'b0, 8'h88, 1'b0, 1'b0}; // AND ok
    vecs[1] = '{2'b01, 8'hAA, 8'hCC, 1'b0, 8'hEE, 1'b0, 1'b0}; // OR ok
    vecs[2] = '{2'b10, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0}; // ADD ok
    vecs[3] = '{2'b10, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1}; // ADD bad res
    vecs[4] = '{2'b10, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b1, 1'b1}; // ADD bad cout
    vecs[5] = '{2'b00, 8'h0F, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0}; // AND, cout ignored
    vecs[6] = '{2'b11, 8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0}; // reserved: skip
    vecs[7] = '{2'b01, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1}; // OR bad res

    rst_n = 1'b0; start = 1'b0; num_tests = '0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_cin = 1'b0; in_result = '0; in_cout = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Table run: streamed back to back, mismatch checked one cycle after each accept
    do_start(16'd8);
    chk("run in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      tick();
      if (i > 0) chk($sformatf("mismatch beat%0d", i - 1), mismatch, vecs[i-1].exp_mis);
    end
    in_valid = 1'b0;
    chk("drain busy", busy, 1);
    chk("drain done", done, 0);
    chk("drain in_ready", in_ready, 0);
    tick();
    chk("mismatch beat7", mismatch, vecs[7].exp_mis);
    chk("tbl done", done, 1);
    chk("tbl busy", busy, 0);
    chk("tbl pass", pass, 0);
    chk("tbl pass_cnt", pass_cnt, 4);
    chk("tbl fail_cnt", fail_cnt, 3);
    chk("tbl skip_cnt", skip_cnt, 1);
    chk("tbl ff_idx", first_fail_idx, 3);
    chk("tbl ff_vld", first_fail_vld, 1);
    tick();
    chk("mismatch idle low", mismatch, 0);

    // Restart from DONE clears the score on the start cycle
    do_start(16'd1);
    chk("restart busy", busy, 1);
    chk("restart pass_cnt", pass_cnt, 0);
    chk("restart fail_cnt", fail_cnt, 0);
    chk("restart skip_cnt", skip_cnt, 0);
    chk("restart ff_vld", first_fail_vld, 0);
    drive(vecs[0]);
    tick();
    in_valid = 1'b0;
    tick();
    chk("one-beat done", done, 1);
    chk("one-beat pass", pass, 1);
    chk("one-beat pass_cnt", pass_cnt, 1);

    // Empty run: done+pass on the very next cycle
    do_start(16'd0);
    chk("empty done", done, 1);
    chk("empty pass", pass, 1);
    chk("empty pass_cnt", pass_cnt, 0);
    chk("empty busy", busy, 0);

    // Gapped random ADD traffic against a local model, with a stray start mid-run
    do_start(16'd100);
    sent = 0; mis_seen = 0; m_pass = 0; m_fail = 0; m_ffidx = -1; cyc = 0;
    while (sent < 100 && cyc < 2000) begin
      start = (cyc == 20);
      num_tests = 16'd5;
      if ($urandom_range(1, 0) == 1) begin
        v.op = 2'b10; v.a = 8'($urandom); v.b = 8'($urandom); v.cin = 1'($urandom);
        s = {1'b0, v.a} + {1'b0, v.b} + {8'd0, v.cin};
        v.res = s[7:0]; v.cout = s[8];
        if ($urandom_range(3, 0) == 0) begin
          if ($urandom_range(1, 0) == 1) v.res = v.res ^ (8'h01 << $urandom_range(7, 0));
          else v.cout = ~v.cout;
          m_fail++;
          if (m_ffidx < 0) m_ffidx = sent;
        end else begin
          m_pass++;
        end
        v.exp_mis = 1'b0;
        drive(v);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
      mis_seen += int'(mismatch);
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("rand all sent", sent, 100);
    tick();
    mis_seen += int'(mismatch);
    chk("rand done", done, 1);
    chk("rand pass_cnt", pass_cnt, m_pass);
    chk("rand fail_cnt", fail_cnt, m_fail);
    chk("rand skip_cnt", skip_cnt, 0);
    chk("rand mismatch pulses", mis_seen, m_fail);
    chk("rand ff_vld", first_fail_vld, (m_ffidx >= 0));
    if (m_ffidx >= 0) chk("rand ff_idx", first_fail_idx, m_ffidx);
    chk("rand pass", pass, (m_fail == 0));

    // Reset pulse in the middle of a run, with a failing beat in flight
    do_start(16'd10);
    drive(vecs[3]); tick();
    drive(vecs[4]); tick();
    drive(vecs[0]); tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrun reset");
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
